// File: rtl/data_memory_unit_pkg.sv
// Shared encodings for the data memory unit: FSM states and access sizes.
package data_memory_unit_pkg;

    typedef enum logic [1:0] {
        MEM_ST_IDLE    = 2'd0,
        MEM_ST_ACCESS0 = 2'd1,
        MEM_ST_ACCESS1 = 2'd2,
        MEM_ST_RESP    = 2'd3
    } mem_state_t;

    localparam logic MEM_SIZE_WORD = 1'b0;
    localparam logic MEM_SIZE_BYTE = 1'b1;

endpackage

// File: rtl/data_memory_unit_data_bram.sv
// Single-port word RAM with per-byte write enables and synchronous read.
// Contents are zeroed at power-up.
module data_bram
    import data_memory_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter     INIT_FILE   = "",
    localparam int BYTES      = DATA_WIDTH / 8,
    localparam int WA         = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic [BYTES-1:0]      we,
    input  logic [WA-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Power-up contents; BRAM flows turn this into the bitstream init image.
    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
    end

    // Byte-lane writes and registered read of the addressed word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_memory_unit.sv
// Byte/word data memory with request/response handshake, little-endian,
// misaligned word accesses split over two RAM cycles.
// Optional feature macro: DATA_MEM_UNALIGNED_EN (enables the split path;
// without it misaligned word accesses return an error).
module data_memory_unit
    import data_memory_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_WIDTH  = $clog2(DEPTH_WORDS * (DATA_WIDTH / 8)),
    parameter     INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_byte,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int WA    = ADDR_WIDTH - OFF_W;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH_WORDS * BYTES - 1);

    mem_state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] a_addr;
    logic                  a_write, a_byte, a_split;
    logic [DATA_WIDTH-1:0] a_wdata, w0;

    logic                  accept;
    logic [ADDR_WIDTH:0]   req_last;
    logic                  req_misalign, req_split, req_illegal;

    logic [OFF_W-1:0]        off;
    logic [WA-1:0]           word0;
    logic [DATA_WIDTH-1:0]   w_base, rd_single, rd_data;
    logic [BYTES-1:0]        be_base;
    logic [2*DATA_WIDTH-1:0] wide_w, wide_r;
    logic [2*BYTES-1:0]      wide_be;

    logic [BYTES-1:0]      ram_we;
    logic [WA-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

    assign accept = req_valid && req_ready;

    // Classify the incoming request: split need and legality (no wrap-around).
    always_comb begin
        req_misalign = (req_byte == MEM_SIZE_WORD) && (req_addr[OFF_W-1:0] != '0);
        req_last     = {1'b0, req_addr} +
                       ((req_byte == MEM_SIZE_BYTE) ? '0 : (ADDR_WIDTH+1)'(BYTES - 1));
`ifdef DATA_MEM_UNALIGNED_EN
        req_split    = req_misalign;
        req_illegal  = req_last > LAST_ADDR;
`else
        req_split    = 1'b0;
        req_illegal  = (req_last > LAST_ADDR) || req_misalign;
`endif
    end

    // Lane steering: store data/enables shifted across a double-word window,
    // load data extracted from one word or merged from {W1,W0}.
    always_comb begin
        off       = a_addr[OFF_W-1:0];
        word0     = a_addr[ADDR_WIDTH-1:OFF_W];
        w_base    = a_byte ? DATA_WIDTH'(a_wdata[7:0]) : a_wdata;
        be_base   = a_byte ? BYTES'(1) : '1;
        wide_w    = {{DATA_WIDTH{1'b0}}, w_base} << {off, 3'b000};
        wide_be   = {{BYTES{1'b0}}, be_base} << off;
        wide_r    = {ram_rdata, w0} >> {off, 3'b000};
        rd_single = ram_rdata >> {off, 3'b000};
        rd_data   = a_byte ? DATA_WIDTH'(rd_single[7:0]) : rd_single;
    end

    // RAM port: the first word is read on the accept edge so its data is
    // ready by the end of ACCESS0; loads then prefetch the second word.
    always_comb begin
        ram_addr  = word0;
        ram_we    = '0;
        ram_wdata = wide_w[DATA_WIDTH-1:0];
        case (state)
            MEM_ST_IDLE:    ram_addr = req_addr[ADDR_WIDTH-1:OFF_W];
            MEM_ST_ACCESS0: begin
                if (a_write) ram_we   = wide_be[BYTES-1:0];
                else         ram_addr = word0 + WA'(1);
            end
            MEM_ST_ACCESS1: begin
                ram_addr  = word0 + WA'(1);
                ram_wdata = wide_w[2*DATA_WIDTH-1:DATA_WIDTH];
                if (a_write) ram_we = wide_be[2*BYTES-1:BYTES];
            end
            default: ;
        endcase
        if (!nreset) ram_we = '0;
    end

    data_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_WORDS(DEPTH_WORDS),
        .INIT_FILE  (INIT_FILE)
    ) u_bram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!nreset) state <= MEM_ST_IDLE;
        else         state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            MEM_ST_IDLE:    if (accept) state_nx = req_illegal ? MEM_ST_RESP : MEM_ST_ACCESS0;
            MEM_ST_ACCESS0: state_nx = a_split ? MEM_ST_ACCESS1 : MEM_ST_RESP;
            MEM_ST_ACCESS1: state_nx = MEM_ST_RESP;
            MEM_ST_RESP:    state_nx = MEM_ST_IDLE;
            default:        state_nx = MEM_ST_IDLE;
        endcase
    end

    // Request capture, W0 latch and registered response outputs.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
        end else begin
            req_ready  <= (state_nx == MEM_ST_IDLE);
            resp_valid <= (state_nx == MEM_ST_RESP);
            if (state == MEM_ST_IDLE && accept) begin
                a_addr     <= req_addr;
                a_write    <= req_write;
                a_byte     <= (req_byte == MEM_SIZE_BYTE);
                a_wdata    <= req_wdata;
                a_split    <= req_split;
                resp_error <= req_illegal;
                resp_rdata <= '0;
            end
            if (state == MEM_ST_ACCESS0) begin
                w0 <= ram_rdata;
                if (!a_write && !a_split) resp_rdata <= rd_data;
            end
            if (state == MEM_ST_ACCESS1 && !a_write) resp_rdata <= wide_r[DATA_WIDTH-1:0];
        end
    end

endmodule
